// File: rtl/led_sequence_monitor.sv
// led_sequence_monitor: receive-side checker for the divided 2-bit LED counter.
// Watches leds[1:0], measures the gap between state changes, and verifies each
// change is a +1 (mod 4) step spaced DIVIDE (+/- TOL) clocks apart. Reports
// lock, last measured period, a good-step count and sticky error flags.
//
// Optional feature macro: LED_SEQUENCE_MONITOR_PERIOD_CHECK_EN
//   defined   - period tolerance check and stall detection are active
//   undefined - only the sequence is checked; err_period stays 0
module led_sequence_monitor #(
   parameter logic [31:0] DIVIDE     = 32'd10000,
   parameter logic [31:0] TOL        = 32'd0,
   parameter logic [7:0]  LOCK_COUNT = 8'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  leds,
   input  logic        clr_err,
   output logic        locked,
   output logic [31:0] period,
   output logic [15:0] steps,
   output logic        err_seq,
   output logic        err_period
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TRACK  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  prev_q, prev_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  good_cnt_q, good_cnt_d;
   logic [31:0] period_q, period_d;
   logic [15:0] steps_q, steps_d;
   logic        err_seq_q, err_seq_d;
   logic        err_period_q, err_period_d;
   logic        locked_q, locked_d;

   logic [1:0]  cur;
   logic        evt;
   logic        seq_ok;
   logic        per_ok;
   logic        stall;
   logic        good;
   logic [1:0]  unused_leds_hi;

   assign cur            = leds[1:0];
   assign unused_leds_hi = leds[3:2];
   assign evt            = (cur != prev_q);
   assign seq_ok         = (cur == 2'(prev_q + 2'd1));
   assign good           = seq_ok && per_ok;

`ifdef LED_SEQUENCE_MONITOR_PERIOD_CHECK_EN
   // Gap compared in a widened domain: lower bound is tested as gap+TOL >= DIVIDE
   // so a TOL larger than DIVIDE can never wrap the bound around.
   logic [33:0] gap_w;
   assign gap_w  = {2'b00, cnt_q} + 34'd1;
   assign per_ok = ((gap_w + {2'b00, TOL}) >= {2'b00, DIVIDE}) &&
                   (gap_w <= ({2'b00, DIVIDE} + {2'b00, TOL}));
   // Source considered stalled once the gap can no longer end in tolerance.
   assign stall  = (cnt_q == (DIVIDE + TOL));
`else
   logic [31:0] unused_lim;
   assign unused_lim = DIVIDE ^ TOL;
   assign per_ok     = 1'b1;
   assign stall      = 1'b0;
`endif

   // Next-state computation for the tracker FSM and all observed outputs.
   always_comb begin
      state_d      = state_q;
      prev_d       = cur;
      cnt_d        = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
      good_cnt_d   = good_cnt_q;
      period_d     = period_q;
      steps_d      = steps_q;
      err_seq_d    = err_seq_q && !clr_err;
      err_period_d = err_period_q && !clr_err;

      if (evt) begin
         cnt_d    = 32'd0;
         period_d = cnt_q + 32'd1;
      end

      case (state_q)
         S_IDLE: begin
            // First change after reset only establishes a reference.
            if (evt) begin
               state_d    = S_TRACK;
               good_cnt_d = 8'd0;
            end
         end
         S_TRACK: begin
            if (evt) begin
               if (good) begin
                  good_cnt_d = good_cnt_q + 8'd1;
                  steps_d    = steps_q + 16'd1;
                  if ((good_cnt_q + 8'd1) == LOCK_COUNT) state_d = S_LOCKED;
               end else begin
                  if (!seq_ok) err_seq_d = 1'b1;
                  if (!per_ok) err_period_d = 1'b1;
                  good_cnt_d = 8'd0;
               end
            end
         end
         S_LOCKED: begin
            if (evt) begin
               if (good) begin
                  steps_d = steps_q + 16'd1;
               end else begin
                  if (!seq_ok) err_seq_d = 1'b1;
                  if (!per_ok) err_period_d = 1'b1;
                  state_d    = S_TRACK;
                  good_cnt_d = 8'd0;
               end
            end else if (stall) begin
               err_period_d = 1'b1;
               state_d      = S_TRACK;
               good_cnt_d   = 8'd0;
            end
         end
         default: begin
            state_d    = S_IDLE;
            good_cnt_d = 8'd0;
         end
      endcase

      locked_d = (state_d == S_LOCKED);
   end

   // State and output registers; reset takes effect immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         prev_q       <= 2'd0;
         cnt_q        <= 32'd0;
         good_cnt_q   <= 8'd0;
         period_q     <= 32'd0;
         steps_q      <= 16'd0;
         err_seq_q    <= 1'b0;
         err_period_q <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         good_cnt_q   <= good_cnt_d;
         period_q     <= period_d;
         steps_q      <= steps_d;
         err_seq_q    <= err_seq_d;
         err_period_q <= err_period_d;
         locked_q     <= locked_d;
      end
   end

   assign locked     = locked_q;
   assign period     = period_q;
   assign steps      = steps_q;
   assign err_seq    = err_seq_q;
   assign err_period = err_period_q;

endmodule

// File: tb/tb_led_sequence_monitor.sv
// Bench for led_sequence_monitor. Two instances share one LED stimulus:
// dut0 with TOL=0 and dut1 with TOL=1 (DIVIDE scaled down to 8). A table of
// hand-computed vectors covers the nominal lock sequence, hand-written
// sequences cover the gap/stall/clear/reset corners, and a random phase runs
// against an event-timestamp reference model checked every clock.
module tb_led_sequence_monitor;

   localparam int DI = 8;
   localparam logic [7:0] LC = 8'd4;
`ifdef LED_SEQUENCE_MONITOR_PERIOD_CHECK_EN
   localparam bit PC = 1'b1;
`else
   localparam bit PC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  leds = 4'd0;
   logic        clr_err = 1'b0;

   logic        locked0, err_seq0, err_per0;
   logic [31:0] period0;
   logic [15:0] steps0;
   logic        locked1, err_seq1, err_per1;
   logic [31:0] period1;
   logic [15:0] steps1;

   led_sequence_monitor #(.DIVIDE(32'(DI)), .TOL(32'd0), .LOCK_COUNT(LC)) dut0 (
      .clk(clk), .rst(rst), .leds(leds), .clr_err(clr_err),
      .locked(locked0), .period(period0), .steps(steps0),
      .err_seq(err_seq0), .err_period(err_per0));

   led_sequence_monitor #(.DIVIDE(32'(DI)), .TOL(32'd1), .LOCK_COUNT(LC)) dut1 (
      .clk(clk), .rst(rst), .leds(leds), .clr_err(clr_err),
      .locked(locked1), .period(period1), .steps(steps1),
      .err_seq(err_seq1), .err_period(err_per1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: remembers the clock index of the last change and
   // derives the gap from it; lock is a run length of good changes.
   int m_cyc = 0;
   int m_tol[2];
   int m_last_ev[2];
   int m_prev[2];
   bit m_started[2];
   bit m_locked[2];
   int m_run[2];
   int m_period[2];
   int m_steps[2];
   bit m_eseq[2];
   bit m_eper[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_last_ev[k] = m_cyc;
         m_prev[k] = 0;
         m_started[k] = 0;
         m_locked[k] = 0;
         m_run[k] = 0;
         m_period[k] = 0;
         m_steps[k] = 0;
         m_eseq[k] = 0;
         m_eper[k] = 0;
      end
   endtask

   task automatic model_edge(input int k, input int l, input bit c);
      int gap;
      bit ns;
      bit np;
      ns = 0;
      np = 0;
      gap = m_cyc - m_last_ev[k];
      if (l != m_prev[k]) begin
         m_period[k] = gap;
         m_last_ev[k] = m_cyc;
         if (!m_started[k]) begin
            m_started[k] = 1;
            m_run[k] = 0;
         end else begin
            ns = (l != (m_prev[k] + 1) % 4);
            np = PC && (gap < DI - m_tol[k] || gap > DI + m_tol[k]);
            if (!ns && !np) begin
               m_steps[k] = (m_steps[k] + 1) % 65536;
               if (!m_locked[k]) begin
                  m_run[k]++;
                  if (m_run[k] == int'(LC)) m_locked[k] = 1;
               end
            end else begin
               m_run[k] = 0;
               m_locked[k] = 0;
            end
         end
      end else if (PC && m_locked[k] && gap == DI + m_tol[k] + 1) begin
         np = 1;
         m_locked[k] = 0;
         m_run[k] = 0;
      end
      m_eseq[k] = ns | (m_eseq[k] & !c);
      m_eper[k] = np | (m_eper[k] & !c);
      m_prev[k] = l;
   endtask

   // One clock: advance model with inputs held across the edge, then compare.
   task automatic tick();
      @(posedge clk);
      m_cyc++;
      for (int k = 0; k < 2; k++) model_edge(k, int'(leds[1:0]), clr_err);
      #1;
      chk("m0_locked", 32'(locked0), 32'(m_locked[0]));
      chk("m0_period", period0, m_period[0]);
      chk("m0_steps", 32'(steps0), m_steps[0]);
      chk("m0_err_seq", 32'(err_seq0), 32'(m_eseq[0]));
      chk("m0_err_period", 32'(err_per0), 32'(m_eper[0]));
      chk("m1_locked", 32'(locked1), 32'(m_locked[1]));
      chk("m1_period", period1, m_period[1]);
      chk("m1_steps", 32'(steps1), m_steps[1]);
      chk("m1_err_seq", 32'(err_seq1), 32'(m_eseq[1]));
      chk("m1_err_period", 32'(err_per1), 32'(m_eper[1]));
   endtask

   task automatic ev(input logic [3:0] v, input bit c);
      leds = v;
      clr_err = c;
      tick();
      clr_err = 1'b0;
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   // Called 1 time unit after an edge: asynchronous reset well between edges.
   task automatic do_reset();
      #2 rst = 1'b1;
      leds = 4'd0;
      clr_err = 1'b0;
      #1;
      chk("rst_locked", 32'({locked0, locked1}), 32'd0);
      chk("rst_period", period0 | period1, 32'd0);
      chk("rst_steps", 32'(steps0 | steps1), 32'd0);
      chk("rst_errs", 32'({err_seq0, err_per0, err_seq1, err_per1}), 32'd0);
      model_reset();
      rst = 1'b0;
   endtask

   // Reset then ideal 0->1->2->3->0->1 run; ends 7 clocks after the 5th change.
   task automatic relock();
      do_reset();
      ev(4'h1, 0); hold(DI - 1);
      ev(4'h2, 0); hold(DI - 1);
      ev(4'h3, 0); hold(DI - 1);
      ev(4'h0, 0); hold(DI - 1);
      ev(4'h1, 0); hold(DI - 1);
      chk("relock_locked", 32'(locked0 & locked1), 32'd1);
   endtask

   typedef struct {
      logic [3:0] v;
      bit         c;
      int         hold_n;
      bit         e_locked;
      int         e_steps;
      bit         e_seq;
      int         e_period;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] v;
      int r;
      int gap;
      bit c;

      m_tol[0] = 0;
      m_tol[1] = 1;

      //            v   clr hold lock steps seq period
      tbl[0]  = '{4'h1, 0, 8, 0, 0,  0, 1};
      tbl[1]  = '{4'h2, 0, 8, 0, 1,  0, 8};
      tbl[2]  = '{4'hB, 0, 8, 0, 2,  0, 8};
      tbl[3]  = '{4'h0, 0, 8, 0, 3,  0, 8};
      tbl[4]  = '{4'h1, 0, 8, 1, 4,  0, 8};
      tbl[5]  = '{4'h6, 0, 8, 1, 5,  0, 8};
      tbl[6]  = '{4'h4, 0, 8, 0, 5,  1, 8};
      tbl[7]  = '{4'h1, 0, 8, 0, 6,  1, 8};
      tbl[8]  = '{4'h2, 0, 8, 0, 7,  1, 8};
      tbl[9]  = '{4'h3, 0, 8, 0, 8,  1, 8};
      tbl[10] = '{4'h0, 0, 8, 1, 9,  1, 8};
      tbl[11] = '{4'h1, 1, 7, 1, 10, 0, 8};

      // Power-on reset, checked before any clock edge.
      #1 rst = 1'b1;
      #2;
      chk("por_outputs", 32'({locked0, err_seq0, err_per0, locked1, err_seq1, err_per1}), 32'd0);
      chk("por_steps_period", period0 | 32'(steps0), 32'd0);
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      // Nominal lock, sequence error, relock, clear with a good step.
      for (int i = 0; i < 12; i++) begin
         ev(tbl[i].v, tbl[i].c);
         chk($sformatf("tbl%0d_locked", i), 32'(locked0), 32'(tbl[i].e_locked));
         chk($sformatf("tbl%0d_steps", i), 32'(steps0), tbl[i].e_steps);
         chk($sformatf("tbl%0d_err_seq", i), 32'(err_seq0), 32'(tbl[i].e_seq));
         chk($sformatf("tbl%0d_err_period", i), 32'(err_per0), 32'd0);
         chk($sformatf("tbl%0d_period", i), period0, tbl[i].e_period);
         hold(tbl[i].hold_n - 1);
      end

      // Short gap of DIVIDE-1 while locked: TOL=0 loses lock, TOL=1 keeps it.
      ev(4'h2, 0);
      chk("short_d0_period", period0, 32'(DI - 1));
      chk("short_d0_locked", 32'(locked0), 32'(!PC));
      chk("short_d0_err_period", 32'(err_per0), 32'(PC));
      chk("short_d0_steps", 32'(steps0), PC ? 32'd10 : 32'd11);
      chk("short_d1_locked", 32'(locked1), 32'd1);
      chk("short_d1_err_period", 32'(err_per1), 32'd0);
      chk("short_d1_steps", 32'(steps1), 32'd11);

      // Stall: flagged exactly DIVIDE+TOL+1 clocks after the last change.
      relock();
      tick();
      chk("stall_d0_early", 32'(locked0), 32'd1);
      tick();
      chk("stall_d0_locked", 32'(locked0), 32'(!PC));
      chk("stall_d0_err_period", 32'(err_per0), 32'(PC));
      chk("stall_d1_early", 32'(locked1), 32'd1);
      tick();
      chk("stall_d1_locked", 32'(locked1), 32'(!PC));
      chk("stall_d1_err_period", 32'(err_per1), 32'(PC));

      // 1->3 skip, clr_err alone, then clr_err colliding with a 2->0 error.
      relock();
      ev(4'h3, 0);
      chk("skip_err_seq", 32'(err_seq0), 32'd1);
      chk("skip_locked", 32'(locked0), 32'd0);
      chk("skip_steps", 32'(steps0), 32'd4);
      hold(DI - 1);
      ev(4'h0, 0); hold(DI - 2);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_alone", 32'(err_seq0), 32'd0);
      ev(4'h1, 0); hold(DI - 1);
      ev(4'h2, 0); hold(DI - 1);
      ev(4'h0, 1);
      chk("clr_vs_err", 32'(err_seq0), 32'd1);
      hold(DI - 1);

      // Reset mid-gap while locked; first change afterwards is not counted.
      relock();
      hold(2);
      do_reset();
      ev(4'h1, 0);
      chk("post_rst_first", 32'(steps0), 32'd0);
      chk("post_rst_first_lock", 32'(locked0), 32'd0);
      hold(DI - 1);
      ev(4'h2, 0);
      chk("post_rst_second", 32'(steps0), 32'd1);
      hold(DI - 1);

      // Random steps, skips, jittered gaps, stalls and clears.
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 99));
         v[1:0] = (r < 85) ? 2'(leds[1:0] + 2'd1) : 2'($urandom_range(0, 3));
         v[3:2] = 2'($urandom_range(0, 3));
         gap = ($urandom_range(0, 99) < 75) ? DI : int'($urandom_range(DI - 3, DI + 4));
         c = ($urandom_range(0, 9) == 0);
         ev(v, c);
         hold(gap - 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_sequence_monitor.md
# led_sequence_monitor

Receive-side checker for the divided LED counter pattern. Samples the 2-bit state on `leds[1:0]` every clock, measures the spacing between state changes, and checks that each change is a +1 (mod 4) step at the expected DIVIDE spacing. It reports a lock indication, the measured period, a step count and sticky error flags, so benches and VPI scripts can observe the LED output without probing the generator's internals.

## Interface
- `DIVIDE`, 10000: expected clock cycles between consecutive state changes; 32-bit, ≥ 2.
- `TOL`, 0: allowed ± deviation of a measured period from DIVIDE; DIVIDE+TOL must fit in 32 bits.
- `LOCK_COUNT`, 4: consecutive good changes needed to assert `locked`; 1..255.

Ports:
- `clk` input 1: rising-edge clock, same domain as the LED source.
- `rst` input 1: asynchronous, active-high reset.
- `leds` input 4: LED bus; only `[1:0]` is checked, `[3:2]` is ignored.
- `clr_err` input 1: synchronous clear of the sticky error flags.
- `locked` output 1: sequence and period tracking established.
- `period` output 32: cycle count of the most recent measured gap.
- `steps` output 16: count of good changes; wraps 65535→0.
- `err_seq` output 1: sticky; a change was not +1 mod 4.
- `err_period` output 1: sticky; a gap was out of tolerance, or the source stalled.

## Operation
- `prev` register (2b, reset 0) is loaded with `leds[1:0]` every edge.
- Event: `leds[1:0] != prev` at a rising edge.
- Gap counter `cnt` (32b, reset 0):
  - On an event: `period <= cnt+1` and `cnt <= 0`.
  - Otherwise: `cnt` increments, saturating at all-ones.
- Good event:
  - Sequence condition: `leds[1:0] == prev+1` (mod 4).
  - Period condition: DIVIDE−TOL ≤ `cnt+1` ≤ DIVIDE+TOL, evaluated with 33-bit arithmetic so there is no underflow when TOL > DIVIDE.
- FSM states: IDLE, TRACK, LOCKED. A `good_cnt` counter (8b) tracks consecutive good events.
- IDLE:
  - First event → TRACK with `good_cnt=0`.
  - This event is not checked and does not count in `steps`, but `period` is still loaded.
- TRACK:
  - Good event: `good_cnt+1` and `steps+1`. When `good_cnt+1 == LOCK_COUNT` → LOCKED.
  - Bad event: set the failing flag(s) and clear `good_cnt`; stay in TRACK.
- LOCKED:
  - Good event: `steps+1`.
  - Bad event: set flag(s) → TRACK, `good_cnt=0`, and `locked` drops on the same edge.
  - Stall: no event at an edge where `cnt == DIVIDE+TOL` → set `err_period` → TRACK.
- Seq and period failures on the same event set both flags.
- `clr_err` clears both flags. If a new error occurs on the same edge, the error wins and the flag stays 1.
- `locked` is 1 exactly when state is LOCKED (registered).

## Timing
- Every output is registered and updates on the same edge the event is sampled.
- Latency from `leds` changing to an output update is 1 clock.
- With an ideal source, lock occurs on the (LOCK_COUNT+1)-th event.
- Stall is flagged DIVIDE+TOL+1 cycles after the last event.
- Reset values: `locked=0`, `period=0`, `steps=0`, `err_seq=0`, `err_period=0`, state IDLE, `prev=0`, `cnt=0`, `good_cnt=0`.
- Reset asserted mid-operation forces all of the above immediately, without waiting for a clock edge.
- After reset release, the first event is treated as an IDLE event, even when it is a legal 0→1 step.

## Configuration
- `LED_SEQUENCE_MONITOR_PERIOD_CHECK_EN` defined:
  - Period condition and stall detection are active as described above.
- `LED_SEQUENCE_MONITOR_PERIOD_CHECK_EN` undefined:
  - The period condition is always true and stall detection is removed.
  - `err_period` is tied to 0.
  - `period` is still measured.
  - Lock and `steps` depend only on the sequence condition.

## Test plan
- Nominal run (DIVIDE=10000, TOL=0, LOCK_COUNT=4): source steps 0→1→2→3→0→1 every 10000 cycles → `locked` rises on the 5th event edge, `period=10000`, `steps=4`, errors 0.
- While locked, drive 1→3 → `err_seq=1` and `locked=0` on that edge, `steps` unchanged. Four further good steps → relock.
- While locked, one gap of 9999 cycles with TOL=0 → `err_period=1`, `period=9999`, `locked=0`. With TOL=1 the same gap keeps lock.
- Freeze `leds` while locked → `err_period=1` and `locked=0` at 10001 cycles after the last event. With the macro undefined, `err_period` stays 0 and `locked` stays 1.
- Set `err_seq`, then pulse `clr_err` alone → flag 0. Pulse `clr_err` on the same edge as a 2→0 step → `err_seq` stays 1.
- Assert `rst` mid-gap while locked → all outputs 0 without waiting for a clock edge. After release, the first step is not counted: `steps` stays 0 until the second event.
